tlc_phase_sequencer: RTL and testbench
======================================

# tlc_phase_sequencer

Programmable phase sequencer for the highway/farm intersection. Owns the phase timer, the configurable phase durations, the latched farm-road request and an optional emergency preempt. Drives the two signal heads directly and exports state and timer for the debug display. Sits between the board clock/sensor inputs and the lamp drivers.

## Interface
- CNT_W, 31: timer and duration-register width.
- DEF_START, 150000000: default all-red start phase, in cycles (3 s at 50 MHz).
- DEF_HWY_MIN, 1500000000: default minimum highway green (30 s).
- DEF_YEL, 150000000: default yellow, both roads (3 s).
- DEF_ALLRED, 50000000: default all-red clearance (1 s).
- DEF_FARM_MIN, 150000000: default minimum farm green (3 s).
- DEF_FARM_MAX, 750000000: default maximum farm green (15 s).
- Clk  in  1  system clock; all logic on the rising edge.
- Rst_n  in  1  reset, synchronous, active-low.
- farmSensor  in  1  farm-road vehicle present (level).
- preempt  in  1  emergency preempt request (level); used only with TLC_PREEMPT_EN.
- cfgWe  in  1  duration register write strobe.
- cfgAddr  in  3  register select: 0 START, 1 HWY_MIN, 2 YEL, 3 ALLRED, 4 FARM_MIN, 5 FARM_MAX; 6–7 ignored.
- cfgData  in  CNT_W  write data, in cycles.
- highwaySignal  out  2  red 2'b00, yellow 2'b01, green 2'b11.
- farmSignal  out  2  same encoding.
- state  out  3  current state code.
- Count  out  CNT_W  phase timer.
- phaseDone  out  1  one-cycle pulse in the last cycle of a phase.

## Operation
- States and codes:
  - S_START 0: both red.
  - S_HWY_GRN 1: highway green, farm red.
  - S_HWY_YEL 2: highway yellow, farm red.
  - S_ALLRED 3: both red.
  - S_FARM_GRN 4: highway red, farm green.
  - S_FARM_YEL 5: highway red, farm yellow.
  - S_PREEMPT 6: highway green, farm red.
- Lamp outputs are a registered Moore decode of state.
- Timer: Count clears to 0 on every state change. Otherwise it increments each cycle and saturates at all-ones.
- `exp(D)` means Count >= D−1. A stored duration of 0 is treated as 1. The comparison uses >=, so a write below the current Count exits the phase on the next edge.
- Transitions:
  - S_START → S_HWY_GRN on exp(START).
  - S_HWY_GRN → S_HWY_YEL on exp(HWY_MIN) && farmReq. Otherwise it holds indefinitely.
  - S_HWY_YEL → S_ALLRED on exp(YEL).
  - S_ALLRED → S_FARM_GRN on exp(ALLRED).
  - S_FARM_GRN → S_FARM_YEL on exp(FARM_MAX), or on exp(FARM_MIN) && !farmSensor.
  - S_FARM_YEL → S_START on exp(YEL).
- farmReq: set in any cycle farmSensor=1. Cleared on entry to S_FARM_GRN. If set and cleared in the same cycle, clear wins. farmSensor seen during S_FARM_GRN affects only the early-exit term.
- phaseDone is high exactly when a transition fires next edge. It is never high in a hold state (S_HWY_GRN without request, S_PREEMPT).
- Config writes take effect the next cycle, in any state. A register read by the current phase is honoured immediately.
- Reset values: state=S_START; Count=0; both signals red (2'b00); phaseDone=0; farmReq=0; all duration registers = DEF_* parameters.
- Reset mid-phase abandons the phase without passing through yellow.

## Timing
- Each phase lasts exactly max(D,1) cycles from entry. S_HWY_GRN lasts max(HWY_MIN, first cycle farmReq seen + 1).
- Lamp and state outputs change on the same edge as the transition; there is no extra latency.
- A cfgWe in the same cycle as a phase exit updates the register but does not alter that exit.

## Configuration
- TLC_PREEMPT_EN defined:
  - preempt=1 in S_START or S_HWY_GRN → S_PREEMPT next edge.
  - preempt=1 in S_FARM_GRN → S_FARM_YEL immediately.
  - S_HWY_YEL, S_ALLRED and S_FARM_YEL complete normally. On exit, if preempt=1, they go to S_PREEMPT instead of the normal target.
  - S_PREEMPT holds while preempt=1. On release it goes to S_HWY_GRN with Count=0.
  - farmReq is retained through preempt.
- TLC_PREEMPT_EN undefined: the preempt port exists but is ignored, and S_PREEMPT is unreachable.

## Structure
- Package tlc_pkg holds:
  - state codes;
  - lamp encodings RED/YELLOW/GREEN;
  - cfgAddr constants;
  - default durations.
- Sub-module tlc_phase_timer: saturating counter with clear and the exp() compare. The FSM, request latch and config registers stay in the top.

## Test plan
- Config START=4, HWY_MIN=10, YEL=3, ALLRED=2, FARM_MIN=3, FARM_MAX=8. Pulse farmSensor one cycle at cycle 20:
  - sequence 0(4)→1(…)→2(3)→3(2)→4(3)→5(3)→0;
  - farmSensor low at FARM_MIN expiry, so farm green lasts 3 cycles.
- Same config with farmSensor held high: farm green lasts 8 cycles; farmReq re-latches, so highway green lasts exactly 10 cycles next round.
- No farmSensor: state stays 1 indefinitely (check 1000 cycles); phaseDone never pulses.
- Write HWY_MIN=2 when Count=50 in state 1 with farmReq set: exit next edge, and phaseDone is seen one cycle.
- Assert Rst_n low mid S_FARM_GRN: next edge state=0, Count=0, lamps 00/00, registers back to DEF_*.
- TLC_PREEMPT_EN, preempt during S_FARM_GRN: →5 for YEL cycles →6, held while preempt=1, release →1 with Count=0.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared definitions for the highway/farm traffic-light sequencer:
// state codes, lamp encodings, config register addresses and default durations.
package tlc_pkg;

    typedef enum logic [2:0] {
        S_START    = 3'd0,
        S_HWY_GRN  = 3'd1,
        S_HWY_YEL  = 3'd2,
        S_ALLRED   = 3'd3,
        S_FARM_GRN = 3'd4,
        S_FARM_YEL = 3'd5,
        S_PREEMPT  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b11
    } lamp_t;

    localparam logic [2:0] A_START    = 3'd0;
    localparam logic [2:0] A_HWY_MIN  = 3'd1;
    localparam logic [2:0] A_YEL      = 3'd2;
    localparam logic [2:0] A_ALLRED   = 3'd3;
    localparam logic [2:0] A_FARM_MIN = 3'd4;
    localparam logic [2:0] A_FARM_MAX = 3'd5;

    // Defaults in 50 MHz clock cycles
    localparam int unsigned TLC_DEF_START    = 150000000;
    localparam int unsigned TLC_DEF_HWY_MIN  = 1500000000;
    localparam int unsigned TLC_DEF_YEL      = 150000000;
    localparam int unsigned TLC_DEF_ALLRED   = 50000000;
    localparam int unsigned TLC_DEF_FARM_MIN = 150000000;
    localparam int unsigned TLC_DEF_FARM_MAX = 750000000;

    function automatic lamp_t hwy_lamp(input state_t s);
        case (s)
            S_HWY_GRN, S_PREEMPT: return GREEN;
            S_HWY_YEL:            return YELLOW;
            default:              return RED;
        endcase
    endfunction

    function automatic lamp_t farm_lamp(input state_t s);
        case (s)
            S_FARM_GRN: return GREEN;
            S_FARM_YEL: return YELLOW;
            default:    return RED;
        endcase
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer: saturating up-counter cleared on phase change, with two
// expiry compares (main duration and an early-exit duration).
// A duration of 0 behaves as 1, so the limit is max(dur,1)-1.
module tlc_phase_timer #(
    parameter int unsigned CNT_W = 31
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] dur,
    input  logic [CNT_W-1:0] durEarly,
    output logic [CNT_W-1:0] Count,
    output logic             expired,
    output logic             expiredEarly
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] lim;
    logic [CNT_W-1:0] limEarly;

    assign lim          = (dur == '0) ? '0 : dur - ONE;
    assign limEarly     = (durEarly == '0) ? '0 : durEarly - ONE;
    assign expired      = (Count >= lim);
    assign expiredEarly = (Count >= limEarly);

    // Count cycles within the phase, restart on phase change, stick at all-ones
    always_ff @(posedge Clk) begin
        if (!Rst_n || clr) begin
            Count <= '0;
        end else if (Count != '1) begin
            Count <= Count + ONE;
        end
    end

endmodule

// File: rtl/tlc_phase_sequencer.sv
// Highway/farm intersection phase sequencer. Holds the phase FSM, the latched
// farm-road request and the programmable phase durations; drives both signal
// heads as a registered decode of the next state.
// Optional emergency preempt is compiled in when TLC_PREEMPT_EN is defined.
module tlc_phase_sequencer
    import tlc_pkg::*;
#(
    parameter int unsigned CNT_W        = 31,
    parameter int unsigned DEF_START    = TLC_DEF_START,
    parameter int unsigned DEF_HWY_MIN  = TLC_DEF_HWY_MIN,
    parameter int unsigned DEF_YEL      = TLC_DEF_YEL,
    parameter int unsigned DEF_ALLRED   = TLC_DEF_ALLRED,
    parameter int unsigned DEF_FARM_MIN = TLC_DEF_FARM_MIN,
    parameter int unsigned DEF_FARM_MAX = TLC_DEF_FARM_MAX
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             farmSensor,
    input  logic             preempt,
    input  logic             cfgWe,
    input  logic [2:0]       cfgAddr,
    input  logic [CNT_W-1:0] cfgData,
    output logic [1:0]       highwaySignal,
    output logic [1:0]       farmSignal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] Count,
    output logic             phaseDone
);

    state_t           stateQ;
    state_t           stateNxt;
    logic             farmReq;
    logic             expired;
    logic             expiredEarly;
    logic [CNT_W-1:0] durSel;
    logic [CNT_W-1:0] durStart;
    logic [CNT_W-1:0] durHwyMin;
    logic [CNT_W-1:0] durYel;
    logic [CNT_W-1:0] durAllred;
    logic [CNT_W-1:0] durFarmMin;
    logic [CNT_W-1:0] durFarmMax;
    logic             phaseChange;
    logic             enterFarmGrn;

    assign phaseChange  = (stateNxt != stateQ);
    assign enterFarmGrn = (stateNxt == S_FARM_GRN) && (stateQ != S_FARM_GRN);
    assign state        = stateQ;
    assign phaseDone    = Rst_n && phaseChange;

`ifndef TLC_PREEMPT_EN
    logic unusedPreempt;
    assign unusedPreempt = preempt;
`endif

    tlc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .clr          (phaseChange),
        .dur          (durSel),
        .durEarly     (durFarmMin),
        .Count        (Count),
        .expired      (expired),
        .expiredEarly (expiredEarly)
    );

    // Duration registers: writable at any time, effective from the next cycle
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            durStart   <= CNT_W'(DEF_START);
            durHwyMin  <= CNT_W'(DEF_HWY_MIN);
            durYel     <= CNT_W'(DEF_YEL);
            durAllred  <= CNT_W'(DEF_ALLRED);
            durFarmMin <= CNT_W'(DEF_FARM_MIN);
            durFarmMax <= CNT_W'(DEF_FARM_MAX);
        end else if (cfgWe) begin
            case (cfgAddr)
                A_START:    durStart   <= cfgData;
                A_HWY_MIN:  durHwyMin  <= cfgData;
                A_YEL:      durYel     <= cfgData;
                A_ALLRED:   durAllred  <= cfgData;
                A_FARM_MIN: durFarmMin <= cfgData;
                A_FARM_MAX: durFarmMax <= cfgData;
                default:    ;
            endcase
        end
    end

    // Farm request latch: cleared when farm green starts (clear beats set);
    // sensor activity during farm green only drives the early-exit term
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            farmReq <= 1'b0;
        end else if (enterFarmGrn) begin
            farmReq <= 1'b0;
        end else if (farmSensor && (stateQ != S_FARM_GRN)) begin
            farmReq <= 1'b1;
        end
    end

    // Pick the duration that bounds the current phase
    always_comb begin
        durSel = durStart;
        case (stateQ)
            S_START:    durSel = durStart;
            S_HWY_GRN:  durSel = durHwyMin;
            S_HWY_YEL:  durSel = durYel;
            S_ALLRED:   durSel = durAllred;
            S_FARM_GRN: durSel = durFarmMax;
            S_FARM_YEL: durSel = durYel;
            default:    durSel = durStart;
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stateQ <= S_START;
        end else begin
            stateQ <= stateNxt;
        end
    end

    // Next-state logic; preempt overrides the normal targets when enabled
    always_comb begin
        stateNxt = stateQ;
        case (stateQ)
            S_START:    if (expired)            stateNxt = S_HWY_GRN;
            S_HWY_GRN:  if (expired && farmReq) stateNxt = S_HWY_YEL;
            S_HWY_YEL:  if (expired)            stateNxt = S_ALLRED;
            S_ALLRED:   if (expired)            stateNxt = S_FARM_GRN;
            S_FARM_GRN: if (expired || (expiredEarly && !farmSensor))
                                                stateNxt = S_FARM_YEL;
            S_FARM_YEL: if (expired)            stateNxt = S_START;
            S_PREEMPT:                          stateNxt = S_HWY_GRN;
            default:                            stateNxt = S_START;
        endcase
`ifdef TLC_PREEMPT_EN
        if (preempt) begin
            case (stateQ)
                S_START, S_HWY_GRN, S_PREEMPT: stateNxt = S_PREEMPT;
                S_FARM_GRN:                    stateNxt = S_FARM_YEL;
                default: if (stateNxt != stateQ) stateNxt = S_PREEMPT;
            endcase
        end
`endif
    end

    // Lamps follow the state being entered, so they switch on the same edge
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            highwaySignal <= RED;
            farmSignal    <= RED;
        end else begin
            highwaySignal <= hwy_lamp(stateNxt);
            farmSignal    <= farm_lamp(stateNxt);
        end
    end

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Testbench for tlc_phase_sequencer: directed phase-length scenarios followed
// by randomized stimulus, all compared every cycle against a behavioural model.
// The preempt scenario is included when TLC_PREEMPT_EN is defined.
module tb_tlc_phase_sequencer;

    localparam int CW       = 8;
    localparam int D_START  = 5;
    localparam int D_HWY    = 12;
    localparam int D_YEL    = 3;
    localparam int D_ALLRED = 2;
    localparam int D_FMIN   = 3;
    localparam int D_FMAX   = 9;
    localparam int SAT      = 255;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          farmSensor;
    logic          preempt;
    logic          cfgWe;
    logic [2:0]    cfgAddr;
    logic [CW-1:0] cfgData;
    logic [1:0]    highwaySignal;
    logic [1:0]    farmSignal;
    logic [2:0]    state;
    logic [CW-1:0] Count;
    logic          phaseDone;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    tlc_phase_sequencer #(
        .CNT_W        (CW),
        .DEF_START    (D_START),
        .DEF_HWY_MIN  (D_HWY),
        .DEF_YEL      (D_YEL),
        .DEF_ALLRED   (D_ALLRED),
        .DEF_FARM_MIN (D_FMIN),
        .DEF_FARM_MAX (D_FMAX)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .farmSensor    (farmSensor),
        .preempt       (preempt),
        .cfgWe         (cfgWe),
        .cfgAddr       (cfgAddr),
        .cfgData       (cfgData),
        .highwaySignal (highwaySignal),
        .farmSignal    (farmSignal),
        .state         (state),
        .Count         (Count),
        .phaseDone     (phaseDone)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %0d, required %0d", nm, $time, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase table: successor of each phase and the register bounding it.
    int  nextTab[7] = '{1, 2, 3, 4, 5, 0, 1};
    int  durIdx[7]  = '{0, 1, 2, 3, 5, 2, 0};
    int  hwyTab[7]  = '{0, 3, 1, 0, 0, 0, 3};
    int  farmTab[7] = '{0, 0, 0, 0, 3, 1, 0};
    int  m_reg[6];
    int  m_st   = 0;
    int  m_cnt  = 0;
    bit  m_req  = 0;
    bit  mvalid = 0;

    function automatic bit m_ex(input int d);
        int len;
        len = (d == 0) ? 1 : d;
        return m_cnt >= len - 1;
    endfunction

    function automatic int m_next(input bit fs, input bit pe);
        bit done;
        int n;
        if (m_st == 6)      done = 1;
        else if (m_st == 1) done = m_ex(m_reg[1]) && m_req;
        else if (m_st == 4) done = m_ex(m_reg[5]) || (m_ex(m_reg[4]) && !fs);
        else                done = m_ex(m_reg[durIdx[m_st]]);
        n = done ? nextTab[m_st] : m_st;
`ifdef TLC_PREEMPT_EN
        if (pe) begin
            if (m_st == 0 || m_st == 1 || m_st == 6) n = 6;
            else if (m_st == 4)                      n = 5;
            else if (done)                           n = 6;
        end
`else
        if (pe) n = n;
`endif
        return n;
    endfunction

    // Model advances on every rising edge from the inputs held before it
    always @(posedge Clk) begin
        int n;
        if (!Rst_n) begin
            m_st = 0; m_cnt = 0; m_req = 0; mvalid = 1;
            m_reg = '{D_START, D_HWY, D_YEL, D_ALLRED, D_FMIN, D_FMAX};
        end else if (mvalid) begin
            n = m_next(farmSensor, preempt);
            if (n == 4 && m_st != 4)          m_req = 0;
            else if (farmSensor && m_st != 4) m_req = 1;
            m_cnt = (n != m_st) ? 0 : ((m_cnt < SAT) ? m_cnt + 1 : SAT);
            if (cfgWe && cfgAddr < 3'd6) m_reg[cfgAddr] = int'(cfgData);
            m_st = n;
        end
    end

    // Compare DUT against the model every cycle on the falling edge
    always @(negedge Clk) begin
        int n;
        if (mvalid) begin
            n = m_next(farmSensor, preempt);
            chk("state", 32'(state), m_st);
            chk("count", 32'(Count), m_cnt);
            chk("hwy_lamp", 32'(highwaySignal), hwyTab[m_st]);
            chk("farm_lamp", 32'(farmSignal), farmTab[m_st]);
            chk("phase_done", 32'(phaseDone), (Rst_n && n != m_st) ? 1 : 0);
        end
    end

    // Phase-length logger: last completed run length of each state
    int         lenOf[8];
    logic [2:0] curS   = 3'd0;
    int         runLen = 0;
    always @(posedge Clk) begin
        #1;
        if (state !== curS) begin
            lenOf[curS] = runLen;
            curS        = state;
            runLen      = 1;
        end else begin
            runLen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic wr(input logic [2:0] a, input int d);
        cfgWe = 1'b1; cfgAddr = a; cfgData = CW'(d);
        tick();
        cfgWe = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input string nm);
        int n = 0;
        while (state !== s && n < 2000) begin
            tick();
            n++;
        end
        if (state !== s) begin
            checks++; failures++;
            $display("FAIL %s timeout: state=%0d required=%0d", nm, state, s);
        end
    endtask

    task automatic wait_count(input int c, input string nm);
        int n = 0;
        while (Count !== CW'(c) && n < 2000) begin
            tick();
            n++;
        end
        if (Count !== CW'(c)) begin
            checks++; failures++;
            $display("FAIL %s timeout: count=%0d required=%0d", nm, Count, c);
        end
    endtask

    initial begin
        int bad;
        Rst_n = 1'b0; farmSensor = 1'b0; preempt = 1'b0;
        cfgWe = 1'b0; cfgAddr = 3'd0; cfgData = '0;
        tick(); tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_count", 32'(Count), 0);
        chk("rst_hwy", 32'(highwaySignal), 0);
        chk("rst_farm", 32'(farmSignal), 0);
        chk("rst_done", 32'(phaseDone), 0);
        chk("model_rst_state", m_st, 0);
        Rst_n = 1'b1;

        // Programmed sequence with one sensor pulse at highway-green count 19
        wr(3'd0, 4); wr(3'd1, 10); wr(3'd2, 3); wr(3'd3, 2); wr(3'd4, 3); wr(3'd5, 8);
        wait_state(3'd1, "w_hwy1");
        wait_count(19, "w_cnt19");
        farmSensor = 1'b1; tick(); farmSensor = 1'b0;
        wait_state(3'd0, "w_start1");
        wait_state(3'd1, "w_hwy2");
        chk("len_hwy_pulse", lenOf[1], 21);
        chk("len_hwy_yel", lenOf[2], 3);
        chk("len_allred", lenOf[3], 2);
        chk("len_farm_min", lenOf[4], 3);
        chk("len_farm_yel", lenOf[5], 3);
        chk("len_start", lenOf[0], 4);

        // Sensor held high: farm green runs to max, highway green back to min
        farmSensor = 1'b1;
        wait_state(3'd5, "w_fyel");
        chk("len_farm_max", lenOf[4], 8);
        wait_state(3'd2, "w_hyel");
        chk("len_hwy_relatch", lenOf[1], 10);
        farmSensor = 1'b0;

        // Shrinking HWY_MIN below the running count exits next edge
        wait_state(3'd1, "w_hwy3");
        wr(3'd1, 200);
        wait_count(40, "w_cnt40");
        farmSensor = 1'b1; tick(); farmSensor = 1'b0;
        wait_count(50, "w_cnt50");
        cfgWe = 1'b1; cfgAddr = 3'd1; cfgData = CW'(2);
        tick();
        cfgWe = 1'b0;
        #1;
        chk("wr_done_pulse", 32'(phaseDone), 1);
        chk("wr_count", 32'(Count), 51);
        tick();
        chk("wr_exit_state", 32'(state), 2);
        wr(3'd1, 10);
        wait_state(3'd3, "w_allred");
        chk("len_hwy_wr", lenOf[1], 52);

        // No request: highway green holds, counter saturates
        wait_state(3'd1, "w_hold");
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (state !== 3'd1 || phaseDone !== 1'b0) bad++;
        end
        chk("hold_violations", bad, 0);
        chk("hold_sat_count", 32'(Count), SAT);
        chk("model_sat_count", m_cnt, SAT);

        // Reset in the middle of farm green
        farmSensor = 1'b1; tick(); farmSensor = 1'b0;
        wait_state(3'd4, "w_fgrn");
        tick();
        Rst_n = 1'b0;
        tick();
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_count", 32'(Count), 0);
        chk("mid_rst_hwy", 32'(highwaySignal), 0);
        chk("mid_rst_farm", 32'(farmSignal), 0);
        Rst_n = 1'b1;
        farmSensor = 1'b1;
        wait_state(3'd1, "w_def_hwy");
        wait_state(3'd2, "w_def_yel");
        chk("def_start_len", lenOf[0], D_START);
        chk("def_hwy_len", lenOf[1], D_HWY);
        wait_state(3'd3, "w_def_allred");
        chk("def_yel_len", lenOf[2], D_YEL);
        farmSensor = 1'b0;

`ifdef TLC_PREEMPT_EN
        wait_state(3'd4, "w_pre_fgrn");
        preempt = 1'b1;
        tick();
        chk("pre_to_yel", 32'(state), 5);
        wait_state(3'd6, "w_pre");
        chk("pre_yel_len", lenOf[5], D_YEL);
        repeat (20) tick();
        chk("pre_hold_state", 32'(state), 6);
        chk("pre_hold_done", 32'(phaseDone), 0);
        preempt = 1'b0;
        #1;
        chk("pre_release_done", 32'(phaseDone), 1);
        tick();
        chk("pre_release_state", 32'(state), 1);
        chk("pre_release_count", 32'(Count), 0);
`endif

        // Randomized traffic, config writes, preempt and occasional reset
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0)  farmSensor = ~farmSensor;
            if ($urandom_range(0, 29) == 0) preempt = ~preempt;
            cfgWe   = ($urandom_range(0, 11) == 0);
            cfgAddr = 3'($urandom_range(0, 7));
            cfgData = CW'($urandom_range(0, 12));
            Rst_n   = ($urandom_range(0, 599) != 0);
            tick();
        end
        Rst_n = 1'b1; cfgWe = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
